// File: rtl/seq_sub_cz.sv
// seq_sub_cz: word-serial multi-word subtractor built around one SubCZ.
// Chains the borrow between beats and accumulates a whole-result zero flag.
package lau_pkg;
    typedef enum logic {SLOW, FAST} speed_e;
endpackage

// SubCZ: combinational A - B - CI with borrow out and an A==B zero flag.
module SubCZ #(
    parameter int              width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             CI,
    output logic [width-1:0] S,
    output logic             CO,
    output logic             Z
);
    generate
        if (speed == lau_pkg::FAST) begin : g_fast
            assign {CO, S} = {1'b0, A} - {1'b0, B} - {{width{1'b0}}, CI};
        end else begin : g_slow
            // bit-serial ripple borrow chain
            always_comb begin
                logic b;
                b = CI;
                S = '0;
                for (int i = 0; i < width; i++) begin
                    S[i] = A[i] ^ B[i] ^ b;
                    b    = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & b);
                end
                CO = b;
            end
        end
    endgenerate

    // only meaningful when CI is 0
    assign Z = (A == B);
endmodule

module seq_sub_cz
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter int     words = 4,
    parameter speed_e speed = FAST
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [width-1:0] A_i,
    input  logic [width-1:0] B_i,
    input  logic             CI_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [width-1:0] S_o,
    output logic             CO_o,
    output logic             Z_o,
    output logic             out_last_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);
    localparam int cw = $clog2(words);
    localparam logic [cw-1:0] last_idx = cw'(words - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state_q;
    logic [cw-1:0]   cnt_q;
    logic            bor_q;
    logic            zacc_q;

    logic            acc;
    logic            last;
    logic            cin;
    logic [width-1:0] d_s;
    logic            d_co;
    logic            z_unused;
    logic            zw;
    logic            z_next;

    assign in_ready_o = ~out_valid_o | out_ready_i;
    assign acc        = in_valid_i & in_ready_o;
    assign last       = (cnt_q == last_idx);
    assign cin        = (state_q == IDLE) ? CI_i : bor_q;

    SubCZ #(
        .width(width),
        .speed(speed)
    ) u_sub (
        .A (A_i),
        .B (B_i),
        .CI(cin),
        .S (d_s),
        .CO(d_co),
        .Z (z_unused)
    );

    assign zw     = (d_s == '0);
    assign z_next = (state_q == IDLE) ? zw : (zacc_q & zw);

    // beat sequencing, borrow/zero chaining and the output register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bor_q       <= 1'b0;
            zacc_q      <= 1'b0;
            S_o         <= '0;
            CO_o        <= 1'b0;
            Z_o         <= 1'b0;
            out_last_o  <= 1'b0;
            out_valid_o <= 1'b0;
        end else if (acc) begin
            cnt_q       <= last ? '0 : cnt_q + cw'(1);
            state_q     <= last ? IDLE : RUN;
            bor_q       <= d_co;
            zacc_q      <= z_next;
            S_o         <= d_s;
            CO_o        <= d_co;
            Z_o         <= z_next;
            out_last_o  <= last;
            out_valid_o <= 1'b1;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_sub_cz.sv
// tb_seq_sub_cz: table vectors, hand sequences and a wide-arithmetic
// reference model for seq_sub_cz with width=8, words=4.
module tb_seq_sub_cz;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic       ci;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] s;
    logic       co, z, olast, ovalid;
    logic       out_ready;

    int ncmp = 0;
    int nbad = 0;

    typedef struct packed {
        logic [7:0] s;
        logic       co;
        logic       z;
        logic       last;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        exp_t       e;
    } beat_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic [3:0]  co;
        logic [3:0]  z;
    } vec_t;

    beat_t q[$];
    vec_t  tab[5];

    seq_sub_cz dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .A_i        (a),
        .B_i        (b),
        .CI_i       (ci),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .S_o        (s),
        .CO_o       (co),
        .Z_o        (z),
        .out_last_o (olast),
        .out_valid_o(ovalid),
        .out_ready_i(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_beat(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(ovalid), 32'd1);
        chk({tag, ".s"},     32'(s),      32'(e.s));
        chk({tag, ".co"},    32'(co),     32'(e.co));
        chk({tag, ".z"},     32'(z),      32'(e.z));
        chk({tag, ".last"},  32'(olast),  32'(e.last));
    endtask

    task automatic push_vec(input vec_t v);
        beat_t bt;
        for (int k = 0; k < 4; k++) begin
            bt.a      = v.a[8*k +: 8];
            bt.b      = v.b[8*k +: 8];
            bt.ci     = v.ci;
            bt.e.s    = v.s[8*k +: 8];
            bt.e.co   = v.co[k];
            bt.e.z    = v.z[k];
            bt.e.last = (k == 3);
            q.push_back(bt);
        end
    endtask

    // reference: whole-operand arithmetic, truncated to the first k+1 words
    task automatic push_model(input logic [31:0] av, input logic [31:0] bv, input logic civ);
        longint unsigned mask, la, lb, diff;
        beat_t bt;
        diff = (64'(av) - 64'(bv) - 64'(civ)) & 64'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            mask      = (64'd1 << (8 * (k + 1))) - 64'd1;
            la        = 64'(av) & mask;
            lb        = 64'(bv) & mask;
            bt.a      = av[8*k +: 8];
            bt.b      = bv[8*k +: 8];
            bt.ci     = civ;
            bt.e.s    = diff[8*k +: 8];
            bt.e.co   = (la < lb + 64'(civ));
            bt.e.z    = ((diff & mask) == 64'd0);
            bt.e.last = (k == 3);
            q.push_back(bt);
        end
    endtask

    task automatic drive(input beat_t bt);
        a        = bt.a;
        b        = bt.b;
        ci       = bt.ci;
        in_valid = 1'b1;
    endtask

    // stream the queue with out_ready high, checking each beat one cycle later
    task automatic drain(input bit gaps);
        bit    pend = 1'b0;
        bit    idle = 1'b0;
        exp_t  pe;
        beat_t bt;
        pe = '0;
        while (q.size() > 0 || pend) begin
            @(negedge clk);
            if (pend) check_beat("beat", pe);
            else if (idle) chk("idle.valid", 32'(ovalid), 32'd0);
            if (q.size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
                bt   = q.pop_front();
                drive(bt);
                pe   = bt.e;
                pend = 1'b1;
                idle = 1'b0;
            end else begin
                in_valid = 1'b0;
                pend     = 1'b0;
                idle     = 1'b1;
            end
        end
    endtask

    initial begin
        beat_t bt;
        exp_t  pe;

        tab[0] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 4'b0001, 4'b0000};
        tab[1] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 4'b0000, 4'b1111};
        tab[2] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 4'b1111, 4'b0000};
        tab[3] = '{32'h0000_0001, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0000, 4'b1111};
        tab[4] = '{32'h0000_0002, 32'h0000_0000, 1'b0, 32'h0000_0002, 4'b0000, 4'b0000};

        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pe        = '0;

        repeat (2) @(negedge clk);
        chk("rst.valid", 32'(ovalid), 32'd0);
        chk("rst.s",     32'(s),      32'd0);
        chk("rst.co",    32'(co),     32'd0);
        chk("rst.z",     32'(z),      32'd0);
        chk("rst.last",  32'(olast),  32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // directed vectors, back-to-back
        for (int i = 0; i < 5; i++) push_vec(tab[i]);
        drain(1'b0);

        // backpressure after beat 2
        push_vec(tab[0]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k > 0) check_beat("bp.pre", pe);
            bt = q.pop_front();
            drive(bt);
            pe = bt.e;
        end
        @(negedge clk);
        check_beat("bp.b2", pe);
        out_ready = 1'b0;
        bt = q.pop_front();
        drive(bt);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            check_beat("bp.hold", pe);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_beat("bp.b3", bt.e);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp.drained", 32'(ovalid), 32'd0);

        // reset after two accepted beats
        push_vec(tab[2]);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bt = q.pop_front();
            drive(bt);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        q.delete();
        #1;
        chk("mrst.valid", 32'(ovalid), 32'd0);
        chk("mrst.s",     32'(s),      32'd0);
        chk("mrst.co",    32'(co),     32'd0);
        chk("mrst.z",     32'(z),      32'd0);
        chk("mrst.last",  32'(olast),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst.in_ready", 32'(in_ready), 32'd1);
        push_vec(tab[0]);
        drain(1'b0);

        // randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            if (i % 7 == 0) rb[31:16] = ra[31:16];
            push_model(ra, rb, 1'($urandom_range(0, 1)));
        end
        drain(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
